// File: rtl/btn_cmd_arbiter.sv
// rtl/btn_cmd_arbiter.sv - pushbutton debounce, auto-repeat and round-robin command arbiter
//
// Purpose: synchronizes and debounces N_BTN raw pushbuttons on a shared sample
// tick, raises a fresh-press event on each debounced rising edge plus auto-repeat
// events while a button is held, and serializes all events into one
// valid/ready command stream through a round-robin arbiter.
//
// Ports:
//   clk        in   clock, all state on the rising edge
//   rst_n      in   asynchronous active-low reset
//   btn_raw    in   raw asynchronous button inputs, active-high
//   btn_level  out  debounced button levels
//   cmd_valid  out  command offered (registered)
//   cmd_ready  in   consumer accepts the offered command
//   cmd_id     out  index of the button carried by the command
//   cmd_repeat out  0 = fresh press, 1 = auto-repeat
//   overrun    out  sticky, an event was merged into an already-pending one
module btn_cmd_arbiter #(
  parameter int N_BTN       = 4,
  parameter int TICK_DIV    = 256,
  parameter int STABLE_CNT  = 4,
  parameter int REPEAT_DLY  = 64,
  parameter int REPEAT_RATE = 16,
  localparam int ID_W       = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [ID_W-1:0]  cmd_id,
  output logic             cmd_repeat,
  output logic             overrun
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam int HW = $clog2(REPEAT_DLY + 1);
  localparam int RW = (REPEAT_RATE > 1) ? $clog2(REPEAT_RATE) : 1;

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  logic [N_BTN-1:0] sync1, sync2;
  logic [TW-1:0]    div_cnt;
  logic             tick;
  logic [SW-1:0]    db_cnt [N_BTN];
  logic [HW-1:0]    hold   [N_BTN];
  logic [RW-1:0]    rate   [N_BTN];
  logic [N_BTN-1:0] flip, rise, rpt;
  logic [N_BTN-1:0] pend, rep, grant;
  logic [ID_W-1:0]  rr_ptr, sel, idx_w;
  logic             found;
  state_t           state;

  // Two-flop synchronizer on every raw input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Shared sample-tick divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == TW'(TICK_DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + TW'(1);
    end
  end

  assign tick = (div_cnt == TW'(TICK_DIV - 1));

  // flip: this tick completes the run of differing samples and the level toggles.
  // rpt: hold first reaches REPEAT_DLY, or the saturated-hold rate counter wraps.
  always_comb begin
    flip = '0;
    rise = '0;
    rpt  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      flip[i] = tick && (sync2[i] != btn_level[i]) && (db_cnt[i] == SW'(STABLE_CNT - 1));
      rise[i] = flip[i] && sync2[i];
      if (hold[i] < HW'(REPEAT_DLY)) begin
        rpt[i] = tick && btn_level[i] && (hold[i] == HW'(REPEAT_DLY - 1));
      end else begin
        rpt[i] = tick && btn_level[i] && (rate[i] == RW'(REPEAT_RATE - 1));
      end
    end
  end

  // Debounce, hold/repeat timing and pending-event bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level <= '0;
      pend      <= '0;
      rep       <= '0;
      overrun   <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt[i] <= '0;
        hold[i]   <= '0;
        rate[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (tick) begin
          if (sync2[i] != btn_level[i]) begin
            if (flip[i]) begin
              btn_level[i] <= sync2[i];
              db_cnt[i]    <= '0;
            end else begin
              db_cnt[i] <= db_cnt[i] + SW'(1);
            end
          end else begin
            db_cnt[i] <= '0;
          end
        end

        // hold saturates at REPEAT_DLY; after that the rate counter paces repeats
        if (flip[i]) begin
          hold[i] <= '0;
          rate[i] <= '0;
        end else if (tick && btn_level[i]) begin
          if (hold[i] < HW'(REPEAT_DLY)) begin
            hold[i] <= hold[i] + HW'(1);
          end else if (rate[i] == RW'(REPEAT_RATE - 1)) begin
            rate[i] <= '0;
          end else begin
            rate[i] <= rate[i] + RW'(1);
          end
        end

        // A new event beats a same-cycle grant; only a still-pending event overruns
        if (rise[i] || rpt[i]) begin
          pend[i] <= 1'b1;
          if (pend[i] && !grant[i]) begin
            overrun <= 1'b1;
          end
          if (rise[i]) begin
            rep[i] <= 1'b0;
          end else if (!(pend[i] && !grant[i])) begin
            rep[i] <= 1'b1;
          end
        end else if (grant[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pick: first pending index at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx_w = '0;
    grant = '0;
    for (int k = 0; k < N_BTN; k++) begin
      idx_w = ID_W'((int'(rr_ptr) + k) % N_BTN);
      if (!found && pend[idx_w]) begin
        found = 1'b1;
        sel   = idx_w;
      end
    end
    if (state == S_IDLE && found) begin
      grant[sel] = 1'b1;
    end
  end

  // Command FSM; every output is registered so cmd_ready never reaches an output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cmd_valid  <= 1'b0;
      cmd_id     <= '0;
      cmd_repeat <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            cmd_id     <= sel;
            cmd_repeat <= rep[sel];
            rr_ptr     <= ID_W'((int'(sel) + 1) % N_BTN);
            cmd_valid  <= 1'b1;
            state      <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          cmd_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
